// File: rtl/yc_sync_injector.sv
// Clocked host-side driver for one ycell fabric column. It takes a word over valid/ready,
// sends it LSB-first as dual-rail tokens using a 4-phase return-to-empty handshake, and
// returns the sampled result word over valid/ready.
// Latency: each phase takes at least SYNC+1 cycles, so a full word takes WIDTH*2*(SYNC+1) cycles.
// Backpressure: wr_ready is high only in IDLE. DONE holds rd_valid and rd_data until rd_ready,
// and no new word is accepted until the result has been taken.
// Ports:
//   clk, reset_n       clock and asynchronous active-low reset
//   wr_valid/ready/data  host word in, bit 0 is sent first
//   rd_valid/ready/data  result word out, bit i is the result of token i
//   busy, err, err_clr   busy is high when not IDLE; err is a sticky timeout or illegal-code flag
//   tok, ack, res        dual-rail token out, async ack echo in, async result in
module yc_sync_injector #(
   parameter int WIDTH   = 8,
   parameter int SYNC    = 2,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [WIDTH-1:0] wr_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data,
   output logic             busy,
   output logic             err,
   input  logic             err_clr,
   output logic [1:0]       tok,
   input  logic [1:0]       ack,
   input  logic [1:0]       res
);

   localparam logic [1:0] V_EMPTY = 2'b00;
   localparam logic [1:0] V_0     = 2'b01;
   localparam logic [1:0] V_1     = 2'b10;
   localparam logic [1:0] V_ILL   = 2'b11;

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      S_FLUSH,
      S_IDLE,
      S_SEND,
      S_RTZ,
      S_DONE,
      S_ERR
   } state_t;

   state_t           state, state_nxt;
   logic [1:0]       tok_nxt;
   logic [IW-1:0]    idx, idx_nxt;
   logic [TW-1:0]    tmr, tmr_nxt;
   logic             err_nxt;
   logic [WIDTH-1:0] rd_data_nxt;
   logic [WIDTH-1:0] word, word_nxt;

   logic [1:0] ack_q [SYNC];
   logic [1:0] res_q [SYNC];
   logic [1:0] ack_s, res_s;
   logic       illegal, timed_out;

   // The ack chain resets to a non-empty code so FLUSH cannot mistake the
   // reset value for a drained fabric; FLUSH ignores illegal codes anyway.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC; i++) begin
            ack_q[i] <= V_ILL;
            res_q[i] <= V_EMPTY;
         end
      end else begin
         ack_q[0] <= ack;
         res_q[0] <= res;
         for (int i = 1; i < SYNC; i++) begin
            ack_q[i] <= ack_q[i-1];
            res_q[i] <= res_q[i-1];
         end
      end
   end

   assign ack_s = ack_q[SYNC-1];
   assign res_s = res_q[SYNC-1];

   assign illegal   = (state != S_FLUSH) && ((ack_s == V_ILL) || (res_s == V_ILL));
   assign timed_out = (TIMEOUT != 0) && ((state == S_SEND) || (state == S_RTZ)) &&
                      (tmr == TW'(TIMEOUT));

   always_comb begin
      state_nxt   = state;
      tok_nxt     = tok;
      idx_nxt     = idx;
      err_nxt     = err;
      rd_data_nxt = rd_data;
      word_nxt    = word;

      case (state)
         S_FLUSH: begin
            tok_nxt = V_EMPTY;
            if (ack_s == V_EMPTY) state_nxt = S_IDLE;
         end
         S_IDLE: begin
            if (wr_valid) begin
               word_nxt  = wr_data;
               tok_nxt   = wr_data[0] ? V_1 : V_0;
               idx_nxt   = '0;
               state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            // A matching ack with res still empty keeps us waiting here.
            if ((ack_s == tok) && (res_s != V_EMPTY)) begin
               rd_data_nxt[idx] = (res_s == V_1);
               tok_nxt          = V_EMPTY;
               state_nxt        = S_RTZ;
            end
         end
         S_RTZ: begin
            if (ack_s == V_EMPTY) begin
               if (idx == IW'(WIDTH - 1)) begin
                  state_nxt = S_DONE;
               end else begin
                  idx_nxt   = idx + 1'b1;
                  tok_nxt   = word[idx + 1'b1] ? V_1 : V_0;
                  state_nxt = S_SEND;
               end
            end
         end
         S_DONE: begin
            if (rd_ready) state_nxt = S_IDLE;
         end
         S_ERR: begin
            tok_nxt = V_EMPTY;
            if (err_clr) state_nxt = S_FLUSH;
         end
         default: begin
            tok_nxt   = V_EMPTY;
            state_nxt = S_FLUSH;
         end
      endcase

      if (err_clr) err_nxt = 1'b0;

      // A new error overrides everything above, including a same-cycle err_clr.
      if (illegal || timed_out) begin
         err_nxt   = 1'b1;
         tok_nxt   = V_EMPTY;
         state_nxt = S_ERR;
      end

      if (state_nxt != state)
         tmr_nxt = '0;
      else if ((state == S_SEND) || (state == S_RTZ))
         tmr_nxt = tmr + 1'b1;
      else
         tmr_nxt = '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_FLUSH;
         tok     <= V_EMPTY;
         idx     <= '0;
         tmr     <= '0;
         err     <= 1'b0;
         rd_data <= '0;
         word    <= '0;
      end else begin
         state   <= state_nxt;
         tok     <= tok_nxt;
         idx     <= idx_nxt;
         tmr     <= tmr_nxt;
         err     <= err_nxt;
         rd_data <= rd_data_nxt;
         word    <= word_nxt;
      end
   end

   assign wr_ready = (state == S_IDLE);
   assign rd_valid = (state == S_DONE);
   assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_yc_sync_injector.sv
// Directed bench for yc_sync_injector with a behavioural fabric (loopback, inverting, forced)
// and a scoreboard of expected result words popped on each rd handshake.
module tb_yc_sync_injector;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [7:0] wr_data = 8'h00;
   logic       rd_valid;
   logic       rd_ready = 1'b0;
   logic [7:0] rd_data;
   logic       busy;
   logic       err;
   logic       err_clr = 1'b0;
   logic [1:0] tok;
   logic [1:0] ack;
   logic [1:0] res;

   // fabric mode: 0 loopback, 1 inverting result, 2 forced values
   logic [1:0] mode = 2'd0;
   logic [1:0] ack_force = 2'b00;
   logic [1:0] res_force = 2'b00;

   assign ack = (mode == 2'd2) ? ack_force : tok;
   assign res = (mode == 2'd2) ? res_force : (mode == 2'd1) ? {tok[0], tok[1]} : tok;

   yc_sync_injector #(.WIDTH(8), .SYNC(2), .TIMEOUT(255)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_data  (wr_data),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .rd_data  (rd_data),
      .busy     (busy),
      .err      (err),
      .err_clr  (err_clr),
      .tok      (tok),
      .ack      (ack),
      .res      (res)
   );

   always #5 clk = ~clk;

   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         rd_cnt = 0;
   int         last_rd_cyc = 0;
   logic [7:0] exp_q [$];
   logic [1:0] tok_log [$];
   logic [1:0] tok_prev = 2'b00;
   logic [7:0] sb_exp;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Monitor: token change log and scoreboard pop on each rd handshake.
   always @(negedge clk) begin
      if (tok !== tok_prev) begin
         tok_log.push_back(tok);
         tok_prev = tok;
      end
      if (reset_n && rd_valid && rd_ready) begin
         rd_cnt++;
         last_rd_cyc = cyc;
         checks++;
         assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL sb_unexpected: observed rd_data=%0h expected no result", rd_data);
         end
         if (exp_q.size() > 0) begin
            sb_exp = exp_q.pop_front();
            checks++;
            assert (rd_data === sb_exp) else begin
               errors++;
               $error("FAIL sb_data: observed=%0h expected=%0h", rd_data, sb_exp);
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic send_word(input logic [7:0] w, input bit track, input logic [7:0] expv,
                            output int acc);
      int n = 0;
      wr_data  = w;
      wr_valid = 1'b1;
      while (wr_ready !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("accept_bound", (n < 400), 1);
      if (track) exp_q.push_back(expv);
      @(negedge clk);
      acc      = cyc;
      wr_valid = 1'b0;
   endtask

   task automatic wait_rd(output int at);
      int n = 0;
      while (rd_valid !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("rd_bound", (n < 2000), 1);
      at = cyc;
   endtask

   task automatic wait_err(output int at);
      int n = 0;
      while (err !== 1'b1 && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk("err_bound", (n < 600), 1);
      at = cyc;
   endtask

   task automatic wait_ready(output int at);
      int n = 0;
      while (wr_ready !== 1'b1 && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk("ready_bound", (n < 600), 1);
      at = cyc;
   endtask

   initial begin
      int         acc, at, n, base, hold_ok;
      logic [7:0] w;
      logic [31:0] obs_seq, exp_seq;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_tok", tok, 2'b00);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_busy", busy, 1);
      chk("rst_err", err, 0);
      chk("rst_rd_data", rd_data, 8'h00);
      reset_n = 1'b1;
      wait_ready(at);
      chk("idle_busy", busy, 0);

      // 1: loopback 0xA5, token sequence and latency
      rd_ready = 1'b1;
      w = 8'hA5;
      tok_log.delete();
      send_word(w, 1'b1, w, acc);
      wait_rd(at);
      chk("t1_latency", at - acc, 48);
      chk("t1_rd_data", rd_data, 8'hA5);
      exp_seq = '0;
      for (int i = 0; i < 8; i++) exp_seq[4*i +: 2] = w[i] ? 2'b10 : 2'b01;
      obs_seq = '0;
      for (int i = 0; i < 16 && i < tok_log.size(); i++) obs_seq[2*i +: 2] = tok_log[i];
      chk("t1_tok_count", tok_log.size(), 16);
      chk("t1_tok_seq", obs_seq, exp_seq);
      repeat (3) @(negedge clk);

      // 2: inverting fabric 0x3C -> 0xC3, then hold rd_ready low
      mode = 2'd1;
      rd_ready = 1'b0;
      w = 8'h3C;
      send_word(w, 1'b1, ~w, acc);
      wait_rd(at);
      hold_ok = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rd_valid !== 1'b1 || rd_data !== 8'hC3 || wr_ready !== 1'b0) hold_ok = 0;
      end
      chk("t2_hold_stable", hold_ok, 1);
      chk("t2_rd_data", rd_data, 8'hC3);
      base = rd_cnt;
      rd_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("t2_popped", rd_cnt, base + 1);
      mode = 2'd0;

      // 3: ack stuck empty -> timeout 256 cycles after tok leaves empty
      mode = 2'd2;
      ack_force = 2'b00;
      res_force = 2'b00;
      send_word(8'h01, 1'b0, 8'h00, acc);
      chk("t3_tok_active", tok, 2'b10);
      wait_err(at);
      chk("t3_timeout_cycle", at - acc, 256);
      chk("t3_tok_empty", tok, 2'b00);
      chk("t3_wr_ready", wr_ready, 0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("t3_err_cleared", err, 0);
      chk("t3_flush_busy", busy, 1);
      wait_ready(at);
      chk("t3_idle_err", err, 0);
      mode = 2'd0;

      // 4: illegal ack during bit 2
      base = rd_cnt;
      send_word(8'hFF, 1'b0, 8'h00, acc);
      repeat (12) @(negedge clk);
      chk("t4_bit2_tok", tok, 2'b10);
      ack_force = 2'b11;
      res_force = 2'b10;
      mode = 2'd2;
      n = 0;
      while (err !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t4_err_within", (n <= 3) && (err === 1'b1), 1);
      chk("t4_tok_empty", tok, 2'b00);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("t4_err_wins", err, 1);
      ack_force = 2'b00;
      res_force = 2'b00;
      repeat (40) @(negedge clk);
      chk("t4_no_rd", rd_cnt, base);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("t4_err_clr", err, 0);
      wait_ready(at);
      mode = 2'd0;

      // 5: reset during bit 3 SEND with ack held at V1
      send_word(8'hFF, 1'b0, 8'h00, acc);
      repeat (19) @(negedge clk);
      chk("t5_bit3_tok", tok, 2'b10);
      ack_force = 2'b10;
      res_force = 2'b10;
      mode = 2'd2;
      reset_n = 1'b0;
      #1;
      chk("t5_rst_tok", tok, 2'b00);
      chk("t5_rst_wr_ready", wr_ready, 0);
      chk("t5_rst_rd_data", rd_data, 8'h00);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("t5_held_flush", {wr_ready, busy}, 2'b01);
      ack_force = 2'b00;
      res_force = 2'b00;
      n = 0;
      while (wr_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t5_flush_cycles", n, 3);
      mode = 2'd0;
      send_word(8'h01, 1'b1, 8'h01, acc);
      wait_rd(at);
      chk("t5_rd_data", rd_data, 8'h01);
      repeat (3) @(negedge clk);

      // 6: back-to-back 0xFF then 0x00
      base = rd_cnt;
      rd_ready = 1'b1;
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h00);
      wr_data = 8'hFF;
      wr_valid = 1'b1;
      n = 0;
      while (wr_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      wr_data = 8'h00;
      wait_ready(at);
      chk("t6_first_rd", rd_cnt, base + 1);
      chk("t6_accept_gap", at - last_rd_cyc, 1);
      @(negedge clk);
      wr_valid = 1'b0;
      wait_rd(at);
      repeat (3) @(negedge clk);
      chk("t6_second_rd", rd_cnt, base + 2);

      chk("sb_empty", exp_q.size(), 0);
      chk("rd_total", rd_cnt, 5);
      chk("final_err", err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
